// File: rtl/cgra0_conf_receiver.sv
// PE-side receiver for the cgra0 64-bit configuration bus: captures chunks into a shadow register,
// commits them atomically and forwards traffic downstream. Define CGRA0_CONF_RX_FORWARD_ALL_EN to forward own-id words too.
module cgra0_conf_receiver #(
    parameter logic [15:0] PE_ID      = 16'h0001,
    parameter int          CONF_WIDTH = 120
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           conf_in_bus,
    output logic [63:0]           conf_out_bus,
    output logic [CONF_WIDTH-1:0] pe_conf,
    output logic                  pe_conf_valid,
    output logic                  conf_err,
    output logic [7:0]            chunks_loaded
);

    localparam int          CHUNK_W      = 40;
    localparam int          NUM_CHUNKS   = (CONF_WIDTH + CHUNK_W - 1) / CHUNK_W;
    localparam int          SHADOW_W     = NUM_CHUNKS * CHUNK_W;
    localparam logic [7:0]  NUM_CHUNKS_B = 8'(NUM_CHUNKS);
    localparam logic [7:0]  COMMIT_IDX   = 8'hFF;
    localparam logic [15:0] BCAST_ID     = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [63:0]             r_out_bus;
    logic [SHADOW_W-1:0]     r_shadow;
    logic [NUM_CHUNKS-1:0]   r_mask;
    logic [CONF_WIDTH-1:0]   r_pe_conf;
    logic                    r_err;
    logic [7:0]              r_chunks;

    logic [15:0]             w_id;
    logic [7:0]              w_idx;
    logic [CHUNK_W-1:0]      w_payload;
    logic                    w_match;
    logic                    w_data;
    logic                    w_commit;
    logic                    w_bad_idx;
    logic                    w_complete;
    logic                    w_first_write;
    logic                    w_pe_conf_valid;

    assign w_id      = conf_in_bus[63:48];
    assign w_idx     = conf_in_bus[47:40];
    assign w_payload = conf_in_bus[39:0];

    assign w_match    = (w_id != 16'h0000) && ((w_id == PE_ID) || (w_id == BCAST_ID));
    assign w_data     = w_match && (w_idx < NUM_CHUNKS_B);
    assign w_commit   = w_match && (w_idx == COMMIT_IDX);
    assign w_bad_idx  = w_match && !w_data && !w_commit;
    // Only a LOAD state with every chunk present may commit; COMMIT/IDLE always see an empty mask.
    assign w_complete = (r_state == S_LOAD) && (&r_mask);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_first_write = 1'b0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (int'(w_idx) == c) begin
                w_first_write = !r_mask[c];
            end
        end
    end

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_data) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_commit) w_state_nxt = w_complete ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: begin
                w_state_nxt = w_data ? S_LOAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_pe_conf_valid = (r_state == S_COMMIT);
    end

    // Datapath: forwarding, shadow capture, commit and error tracking.
    // NOTE: the shadow is an ordinary register bank, so it is reset with everything else to discard partial loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_bus <= '0;
            r_shadow  <= '0;
            r_mask    <= '0;
            r_pe_conf <= '0;
            r_err     <= 1'b0;
            r_chunks  <= '0;
        end else begin
`ifdef CGRA0_CONF_RX_FORWARD_ALL_EN
            r_out_bus <= conf_in_bus;
`else
            r_out_bus <= (w_id == PE_ID) ? 64'h0 : conf_in_bus;
`endif
            if (w_data) begin
                for (int c = 0; c < NUM_CHUNKS; c++) begin
                    if (int'(w_idx) == c) begin
                        r_shadow[c*CHUNK_W +: CHUNK_W] <= w_payload;
                        r_mask[c]                      <= 1'b1;
                    end
                end
                if (w_first_write) begin
                    r_chunks <= r_chunks + 8'd1;
                end
            end
            if (w_commit) begin
                r_mask   <= '0;
                r_chunks <= '0;
                if (w_complete) begin
                    r_pe_conf <= r_shadow[CONF_WIDTH-1:0];
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (w_bad_idx) begin
                r_err <= 1'b1;
            end
        end
    end

    assign conf_out_bus  = r_out_bus;
    assign pe_conf       = r_pe_conf;
    assign pe_conf_valid = w_pe_conf_valid;
    assign conf_err      = r_err;
    assign chunks_loaded = r_chunks;

endmodule
